// File: rtl/seg_scan_capture_if.sv
// seg_scan_capture_if
//   Bundles the snooped 7-segment display bus and the recovered-value outputs.
//   The display side (or a bench standing in for it) uses the master modport.
//   The capture block uses the slave modport.
// Signals
//   seg         7            segments, active-low; bit0=A .. bit6=G
//   strobe      NUM_DIGITS   digit anodes, active-low; bit i = digit i
//   data        4*NUM_DIGITS last published value; digit i -> data[4i+3:4i]
//   data_valid  1            one-cycle pulse when data takes a new value
//   locked      1            high once any value has been published
//   frame_err   1            one-cycle pulse when a frame is discarded
interface seg_scan_capture_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   strobe;
  logic [4*NUM_DIGITS-1:0] data;
  logic                    data_valid;
  logic                    locked;
  logic                    frame_err;

  modport master (
    output seg,
    output strobe,
    input  data,
    input  data_valid,
    input  locked,
    input  frame_err
  );

  modport slave (
    input  seg,
    input  strobe,
    output data,
    output data_valid,
    output locked,
    output frame_err
  );
endinterface

// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Snoops a multiplexed 7-segment display bus, waits for each strobed digit to
//   settle, decodes the segments back to a hex nibble and reassembles the full
//   value. A value is published only after MATCH_FRAMES identical clean frames.
// Ports
//   clock    system clock, all logic on the rising edge
//   reset_n  synchronous active-low reset
//   bus      seg_scan_capture_if slave: seg/strobe in, data/data_valid/locked/frame_err out
module seg_scan_capture #(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MATCH_FRAMES  = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  seg_scan_capture_if.slave  bus
);

  localparam int unsigned DW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_HOLD
  } state_t;

  state_t                state, state_next;
  logic [7:0]            counter, counter_next;
  logic [NUM_DIGITS-1:0] strobe_lat, lat_next;
  logic                  start_settle, do_sample, do_abort;

  logic [NUM_DIGITS-1:0] low_now, low_lat;
  logic                  is_blank, is_one, is_multi;

  logic [3:0]            nib;
  logic                  seg_ok;

  logic [NUM_DIGITS-1:0] seen, seen_acc;
  logic                  dirty, dirty_acc, repeat_digit;
  logic [DW-1:0]         buffer, buf_acc, candidate;
  logic [3:0]            match_cnt;

  // Strobes are active-low; a single low bit is a valid digit select.
  // x & (x-1) clears the lowest set bit, so it is zero only for one-hot x.
  assign low_now  = ~bus.strobe;
  assign low_lat  = ~strobe_lat;
  assign is_blank = (low_now == '0);
  assign is_one   = !is_blank && ((low_now & (low_now - NUM_DIGITS'(1))) == '0);
  assign is_multi = !is_blank && !is_one;

  // Segment pattern back to a nibble; anything not in the hex font is flagged.
  always_comb begin
    nib    = 4'h0;
    seg_ok = 1'b1;
    case (bus.seg)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: seg_ok = 1'b0;
    endcase
  end

  // State register for the settle/sample sequencer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      counter    <= 8'd0;
      strobe_lat <= '1;
    end else begin
      state      <= state_next;
      counter    <= counter_next;
      strobe_lat <= lat_next;
    end
  end

  // Next-state logic. A new digit always restarts the settle count at 1;
  // SAMPLE is entered on the edge the count reaches SETTLE_CYCLES, so seg
  // is captured SETTLE_CYCLES+1 edges after the digit first appears.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    lat_next     = strobe_lat;
    start_settle = 1'b0;
    do_sample    = 1'b0;
    do_abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_one) start_settle = 1'b1;
      end
      ST_SETTLE, ST_HOLD: begin
        if (is_multi) begin
          do_abort   = 1'b1;
          state_next = ST_IDLE;
        end else if (is_blank) begin
          state_next = ST_IDLE;
        end else if (bus.strobe != strobe_lat) begin
          start_settle = 1'b1;
        end else if (state == ST_SETTLE) begin
          if (counter != 8'hFF) counter_next = counter + 8'd1;
          if (counter == 8'(SETTLE_CYCLES - 1)) state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        do_sample  = 1'b1;
        state_next = ST_HOLD;
      end
      default: state_next = ST_IDLE;
    endcase
    if (start_settle) begin
      lat_next     = bus.strobe;
      counter_next = 8'd1;
      state_next   = (SETTLE_CYCLES == 1) ? ST_SAMPLE : ST_SETTLE;
    end
  end

  // What the frame would look like if the current sample were accepted.
  always_comb begin
    seen_acc     = seen | low_lat;
    dirty_acc    = dirty | !seg_ok;
    repeat_digit = |(seen & low_lat);
    buf_acc      = buffer;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (low_lat[i]) buf_acc[4*i +: 4] = seg_ok ? nib : 4'h0;
    end
  end

  // Frame assembly, match counting and publishing. Publishing looks at the
  // registered match count, so it lands the cycle after a frame completes.
  // A repeated digit restarts the frame from that sample, keeping its own
  // decode status so a bad pattern is never silently accepted.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      seen           <= '0;
      dirty          <= 1'b0;
      buffer         <= '0;
      candidate      <= '0;
      match_cnt      <= 4'd0;
      bus.data       <= '0;
      bus.data_valid <= 1'b0;
      bus.locked     <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      if (match_cnt == 4'(MATCH_FRAMES) && (!bus.locked || candidate != bus.data)) begin
        bus.data       <= candidate;
        bus.data_valid <= 1'b1;
        bus.locked     <= 1'b1;
      end
      if (do_abort) begin
        seen          <= '0;
        dirty         <= 1'b0;
        bus.frame_err <= 1'b1;
      end else if (do_sample) begin
        buffer <= buf_acc;
        if (repeat_digit) begin
          seen          <= low_lat;
          dirty         <= !seg_ok;
          bus.frame_err <= 1'b1;
        end else if (&seen_acc) begin
          seen  <= '0;
          dirty <= 1'b0;
          if (dirty_acc) begin
            bus.frame_err <= 1'b1;
            match_cnt     <= 4'd0;
          end else if (buf_acc == candidate) begin
            if (match_cnt < 4'(MATCH_FRAMES)) match_cnt <= match_cnt + 4'd1;
          end else begin
            candidate <= buf_acc;
            match_cnt <= 4'd1;
          end
        end else begin
          seen  <= seen_acc;
          dirty <= dirty_acc;
        end
      end
    end
  end

endmodule
